// File: rtl/gctr_combine_if.sv
// gctr_combine_if: handshake and data bundle between the AES keystream/text
// sources, the GCTR combine stage and the GHASH/output consumer.
// slave  = view of the combine stage, master = view of its environment.
interface gctr_combine_if;
    logic          i_valid;
    logic [0:127]  i_keystream;
    logic [0:127]  i_text;
    logic          i_last;
    logic [4:0]    i_bytes;
    logic          o_stall;
    logic          o_overflow;
    logic          o_valid;
    logic          i_ready;
    logic [0:127]  o_text;
    logic          o_last;
    logic [4:0]    o_bytes;
    logic [31:0]   o_blk_idx;

    modport slave (
        input  i_valid, i_keystream, i_text, i_last, i_bytes, i_ready,
        output o_stall, o_overflow, o_valid, o_text, o_last, o_bytes, o_blk_idx
    );

    modport master (
        output i_valid, i_keystream, i_text, i_last, i_bytes, i_ready,
        input  o_stall, o_overflow, o_valid, o_text, o_last, o_bytes, o_blk_idx
    );
endinterface

// File: rtl/gctr_combine.sv
// gctr_combine: final GCTR stage of the AES-GCM datapath.
// XORs the bypassed text with the AES keystream, optionally zeroes the tail
// of a partial final block, and queues {block, last, bytes, index} in an
// elastic FIFO. o_stall is raised early enough to absorb every block still
// in flight in the non-stallable AES pipeline; any block that finds the FIFO
// full anyway is dropped and latched in the sticky o_overflow flag.
// Optional feature macro: GCTR_TAIL_MASK_EN (zero bytes at and beyond i_bytes).
module gctr_combine #(
    parameter int DEPTH      = 32,
    parameter int CREDIT_LAT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    gctr_combine_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - CREDIT_LAT - 1);

    // Byte count 0 or above 16 means a whole block.
    function automatic logic [4:0] norm_bytes(input logic [4:0] b);
        logic [4:0] r;
        if ((b == 5'd0) || (b > 5'd16)) begin
            r = 5'd16;
        end else begin
            r = b;
        end
        return r;
    endfunction

    // Zero every byte n >= nb; byte 0 occupies bits [0:7] (most significant).
    function automatic logic [0:127] tail_mask(input logic [0:127] d, input logic [4:0] nb);
        logic [0:127] r;
        r = d;
        for (int n = 0; n < 16; n++) begin
            if (5'(n) >= nb) begin
                r[8*n +: 8] = 8'h00;
            end else begin
                r[8*n +: 8] = d[8*n +: 8];
            end
        end
        return r;
    endfunction

    logic [0:127]  text_mem  [DEPTH];
    logic          last_mem  [DEPTH];
    logic [4:0]    bytes_mem [DEPTH];
    logic [31:0]   idx_mem   [DEPTH];

    logic [CW-1:0] count_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [31:0]   blk_cnt_r;
    logic          overflow_r;

    logic          valid_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [4:0]    nbytes_s;
    logic [0:127]  xor_s;
    logic [0:127]  comb_s;

    assign valid_s  = (count_r != '0);
    assign full_s   = (count_r == FULL_LVL);
    assign pop_s    = valid_s && bus.i_ready;
    // A full FIFO that is popping this cycle frees the slot being written.
    assign push_s   = bus.i_valid && (!full_s || pop_s);
    assign drop_s   = bus.i_valid && full_s && !pop_s;
    assign nbytes_s = norm_bytes(bus.i_bytes);
    assign xor_s    = bus.i_text ^ bus.i_keystream;

`ifdef GCTR_TAIL_MASK_EN
    assign comb_s = tail_mask(xor_s, nbytes_s);
`else
    assign comb_s = xor_s;
`endif

    // Storage array write; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            text_mem[wr_ptr_r]  <= comb_s;
            last_mem[wr_ptr_r]  <= bus.i_last;
            bytes_mem[wr_ptr_r] <= nbytes_s;
            idx_mem[wr_ptr_r]   <= blk_cnt_r;
        end
    end

    // FIFO pointers, occupancy, per-message block index and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r    <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            blk_cnt_r  <= 32'd0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r  <= wr_ptr_r + AW'(1);
                blk_cnt_r <= bus.i_last ? 32'd0 : (blk_cnt_r + 32'd1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Head fields are forced to zero while the FIFO is empty so reset and
    // idle states present a clean, deterministic bus.
    assign bus.o_valid    = valid_s;
    assign bus.o_text     = valid_s ? text_mem[rd_ptr_r]  : '0;
    assign bus.o_last     = valid_s ? last_mem[rd_ptr_r]  : 1'b0;
    assign bus.o_bytes    = valid_s ? bytes_mem[rd_ptr_r] : 5'd0;
    assign bus.o_blk_idx  = valid_s ? idx_mem[rd_ptr_r]   : 32'd0;
    assign bus.o_stall    = (count_r >= STALL_LVL);
    assign bus.o_overflow = overflow_r;
endmodule

// File: doc/gctr_combine.md
# gctr_combine

Final GCTR stage of the AES-GCM datapath: combines the plaintext delayed by the 15-cycle text bypass with the keystream produced by the pipelined AES core, masks the tail of a partial final block, and buffers the result in an elastic FIFO toward the GHASH/output interface. The AES pipeline cannot stall, so this block issues an early back-pressure signal sized to the pipeline latency, and flags any loss of data as a sticky error.

## Interface
Parameters:
- DEPTH, 32: output FIFO entries (power of two, ≥ CREDIT_LAT+2).
- CREDIT_LAT, 15: cycles between upstream counter issue and i_valid; sets the o_stall threshold.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  1  keystream/text pair valid this cycle (no ready; always accepted unless full).
- i_keystream  in  [0:127]  E(K, counter) from the AES pipeline.
- i_text  in  [0:127]  aligned plaintext/ciphertext from the bypass delay line.
- i_last  in  1  final block of the message.
- i_bytes  in  5  valid bytes in block; 1..16; 0 or >16 treated as 16.
- o_stall  out  1  upstream must stop issuing new counters.
- o_overflow  out  1  sticky: a valid input arrived while FIFO full.
- o_valid  out  1  FIFO head valid.
- i_ready  in  1  downstream accepts head.
- o_text  out  [0:127]  combined block.
- o_last  out  1  head is final block.
- o_bytes  out  5  normalised byte count of head (1..16).
- o_blk_idx  out  32  index of head block within its message, first block = 0.

## Operation
- Combine: r = i_text XOR i_keystream; byte n = bits [8n:8n+7], byte 0 most significant.
- Tail mask: bytes n ≥ i_bytes forced to 0x00 (see Configuration).
- Write: i_valid && !full, or i_valid && full && pop this cycle → entry {r, i_last, bytes, blk_cnt} pushed.
- Drop: i_valid && full && !pop → entry discarded, o_overflow set, cleared only by reset.
- Block counter blk_cnt: 32-bit, increments on every accepted write; set to 0 after an accepted write with i_last=1; wraps 0xFFFFFFFF → 0. Dropped entries do not advance it.
- Pop: o_valid && i_ready. Head fields held stable while o_valid && !i_ready.
- Occupancy count: +1 on push only, −1 on pop only, unchanged on both.
- o_stall = (count ≥ DEPTH − CREDIT_LAT − 1), combinational from registered count.

## Timing
- Reset (rst_n=0 at edge): count=0, pointers=0, blk_cnt=0; o_valid=0, o_stall=0, o_overflow=0, o_last=0, o_bytes=0, o_text=0, o_blk_idx=0. Reset mid-message discards all entries; next accepted block has index 0.
- Latency: input sampled at edge N → o_valid=1 from cycle N+1 when FIFO empty (no combinational input→output path).
- Throughput: one push and one pop per cycle sustained.
- Full with simultaneous pop: push accepted, no overflow.
- Empty with i_ready=1: no pop, count stays 0.
- o_stall rises the cycle after count reaches threshold; with CREDIT_LAT in-flight blocks the FIFO never overflows if upstream obeys o_stall.

## Configuration
- GCTR_TAIL_MASK_EN defined: bytes beyond i_bytes zeroed in o_text.
- Undefined: o_text is the full 128-bit XOR for every block; o_bytes still forwarded so downstream masks.

## Test plan
- Full block: i_text=0, i_keystream=0x000102…0F, i_bytes=16, i_last=1 → next cycle o_valid=1, o_text=0x000102…0F, o_bytes=16, o_blk_idx=0.
- Partial tail (mask enabled): i_text=all 0xFF, i_keystream=0, i_bytes=5 → o_text=0xFFFFFFFFFF followed by 11 zero bytes; without macro → all 0xFF; i_bytes=0 → o_bytes=16.
- Index sequencing: 3-block message (last on 3rd) then 2-block message → o_blk_idx 0,1,2,0,1.
- Back-pressure: i_ready=0, 16 writes → o_stall=1 after count reaches 16; fill to 32, 33rd write with i_ready=0 → o_overflow=1, entry lost, later reads return 32 entries in order.
- Full with simultaneous push/pop for 10 cycles → count stays 32, o_overflow=0, FIFO order preserved.
- Reset mid-message after 4 blocks queued → o_valid=0 next cycle; next block emerges with o_blk_idx=0.
